cartridge_prg_bus_ctrl: RTL and testbench

CPU-side PRG bus controller for the cartridge. It decodes CPU accesses in $4020–$FFFF, turns writes to $8000–$FFFF into mapper register writes, and forwards the resulting PRG ROM / PRG RAM offsets to the active mapper. It then takes the mapper's extended address and runs a req/ack transaction to the external PRG memory, returning read data and a `ready` pulse to the CPU core. Unanswered memory requests are aborted by a timeout and return open-bus.

---
 rtl/cartridge_prg_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cartridge_prg_bus_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cartridge_prg_bus_ctrl.sv
// CPU-side PRG bus controller: decodes $4020-$FFFF accesses, issues mapper register
// writes, and runs a timed req/ack transaction to external PRG ROM/RAM.
module cartridge_prg_bus_ctrl #(
    parameter bit          PRG_RAM_EN     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [7:0]  cpu_wr_data_i,
    output logic [7:0]  cpu_rd_data_o,
    output logic        cpu_ready_o,
    output logic        mapper_wr_o,
    output logic [7:0]  mapper_wr_data_o,
    output logic [14:0] prg_rom_addr_o,
    output logic [12:0] prg_ram_addr_o,
    input  logic [18:0] mapped_prg_rom_addr_i,
    input  logic [14:0] mapped_prg_ram_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_sel_o,
    output logic [18:0] mem_addr_o,
    output logic [7:0]  mem_wr_data_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rd_data_i,
    output logic        err_timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MEM   = 2'd1;
    localparam logic [1:0] S_LOCAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        we_q, we_d;
    logic        sel_q, sel_d;
    logic        map_wr_q, map_wr_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  open_bus_q, open_bus_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic strobe;
    logic is_rom;
    logic is_ram;

    assign strobe = cpu_rd_i | cpu_wr_i;
    assign is_rom = cpu_addr_i[15];
    assign is_ram = (cpu_addr_i[15:13] == 3'b011);

    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        we_d       = we_q;
        sel_d      = sel_q;
        map_wr_d   = map_wr_q;
        rd_data_d  = rd_data_q;
        open_bus_d = open_bus_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    // A simultaneous rd+wr is a write.
                    addr_d    = cpu_addr_i[14:0];
                    wr_data_d = cpu_wr_data_i;
                    we_d      = cpu_wr_i;
                    sel_d     = 1'b0;
                    map_wr_d  = 1'b0;
                    if (cpu_wr_i) open_bus_d = cpu_wr_data_i;
                    if (is_rom) begin
                        if (cpu_wr_i) begin
                            map_wr_d = 1'b1;
                            state_d  = S_LOCAL;
                        end else begin
                            cnt_d   = 8'd1;
                            state_d = S_MEM;
                        end
                    end else if (is_ram && PRG_RAM_EN) begin
                        sel_d   = 1'b1;
                        cnt_d   = 8'd1;
                        state_d = S_MEM;
                    end else begin
                        state_d = S_LOCAL;
                    end
                end
            end
            S_MEM: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (mem_ack_i) begin
                    if (!we_q) begin
                        rd_data_d  = mem_rd_data_i;
                        open_bus_d = mem_rd_data_i;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    err_d = 1'b1;
                    if (!we_q) rd_data_d = open_bus_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LOCAL: begin
                if (!we_q) rd_data_d = open_bus_q;
                map_wr_d = 1'b0;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_data_q  <= '0;
            we_q       <= 1'b0;
            sel_q      <= 1'b0;
            map_wr_q   <= 1'b0;
            rd_data_q  <= '0;
            open_bus_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            map_wr_q   <= map_wr_d;
            rd_data_q  <= rd_data_d;
            open_bus_q <= open_bus_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign cpu_rd_data_o    = rd_data_q;
    assign cpu_ready_o      = (state_q == S_DONE);
    assign mapper_wr_o      = (state_q == S_LOCAL) && map_wr_q;
    assign mapper_wr_data_o = wr_data_q;
    assign prg_rom_addr_o   = addr_q;
    assign prg_ram_addr_o   = addr_q[12:0];
    assign mem_req_o        = (state_q == S_MEM);
    assign mem_we_o         = we_q;
    assign mem_sel_o        = sel_q;
    assign mem_wr_data_o    = wr_data_q;
    assign err_timeout_o    = err_q;

    // The mapper inputs are live; gate them so the bus idles at zero outside a request.
    assign mem_addr_o = !mem_req_o ? 19'h0 :
                        sel_q      ? {4'h0, mapped_prg_ram_addr_i} : mapped_prg_rom_addr_i;

endmodule

// File: tb/tb_cartridge_prg_bus_ctrl.sv
// Directed bench for cartridge_prg_bus_ctrl: vector table plus hand-written corner sequences.
module tb_cartridge_prg_bus_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i = 1'b1;
    logic [15:0] cpu_addr_i = '0;
    logic        cpu_rd_i = 1'b0;
    logic        cpu_wr_i = 1'b0;
    logic [7:0]  cpu_wr_data_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_rd_data_i = '0;

    // Instance a: PRG RAM enabled; instance b: PRG RAM disabled. Both time out after 8.
    logic [7:0]  rd_data_a, rd_data_b, mwd_a, mwd_b, wd_a, wd_b;
    logic        ready_a, ready_b, mwr_a, mwr_b, req_a, req_b, we_a, we_b, sel_a, sel_b;
    logic        err_a, err_b;
    logic [14:0] rom_a, rom_b;
    logic [12:0] ram_a, ram_b;
    logic [18:0] maddr_a, maddr_b;

    // Simple mapper: ROM bank 3 fixed in the upper bits, RAM passed straight through.
    logic [18:0] map_rom_a, map_rom_b;
    logic [14:0] map_ram_a, map_ram_b;
    assign map_rom_a = {4'h3, rom_a};
    assign map_rom_b = {4'h3, rom_b};
    assign map_ram_a = {2'b00, ram_a};
    assign map_ram_b = {2'b00, ram_b};

    cartridge_prg_bus_ctrl #(.PRG_RAM_EN(1'b1), .TIMEOUT_CYCLES(8)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_addr_i(cpu_addr_i), .cpu_rd_i(cpu_rd_i),
        .cpu_wr_i(cpu_wr_i), .cpu_wr_data_i(cpu_wr_data_i), .cpu_rd_data_o(rd_data_a),
        .cpu_ready_o(ready_a), .mapper_wr_o(mwr_a), .mapper_wr_data_o(mwd_a),
        .prg_rom_addr_o(rom_a), .prg_ram_addr_o(ram_a),
        .mapped_prg_rom_addr_i(map_rom_a), .mapped_prg_ram_addr_i(map_ram_a),
        .mem_req_o(req_a), .mem_we_o(we_a), .mem_sel_o(sel_a), .mem_addr_o(maddr_a),
        .mem_wr_data_o(wd_a), .mem_ack_i(mem_ack_i), .mem_rd_data_i(mem_rd_data_i),
        .err_timeout_o(err_a)
    );

    cartridge_prg_bus_ctrl #(.PRG_RAM_EN(1'b0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_addr_i(cpu_addr_i), .cpu_rd_i(cpu_rd_i),
        .cpu_wr_i(cpu_wr_i), .cpu_wr_data_i(cpu_wr_data_i), .cpu_rd_data_o(rd_data_b),
        .cpu_ready_o(ready_b), .mapper_wr_o(mwr_b), .mapper_wr_data_o(mwd_b),
        .prg_rom_addr_o(rom_b), .prg_ram_addr_o(ram_b),
        .mapped_prg_rom_addr_i(map_rom_b), .mapped_prg_ram_addr_i(map_ram_b),
        .mem_req_o(req_b), .mem_we_o(we_b), .mem_sel_o(sel_b), .mem_addr_o(maddr_b),
        .mem_wr_data_o(wd_b), .mem_ack_i(mem_ack_i), .mem_rd_data_i(mem_rd_data_i),
        .err_timeout_o(err_b)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
        int          ack_cyc;   // 0 = never ack
        logic [7:0]  ack_data;
        int          exp_ready;
        int          exp_req;
        logic        exp_sel;
        logic        exp_we;
        logic [18:0] exp_maddr;
        logic        exp_map;
        logic        chk_rd;
        logic [7:0]  exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          ready_cyc;
        int          req_cycles;
        int          mapper_cycles;
        int          mapper_first;
        logic        sel;
        logic        we;
        logic [18:0] maddr;
        logic [7:0]  wdata;
        logic [7:0]  mdata;
        logic [7:0]  rd_data;
        logic        err;
        logic        stable;
    } res_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int cyc, input logic req, input logic sel, input logic we,
                          input logic [18:0] maddr, input logic [7:0] wd, input logic mwr,
                          input logic [7:0] mdata, input logic rdy, input logic [7:0] rdd,
                          input logic err, inout res_t r);
        if (r.ready_cyc != 0) return;
        if (req) begin
            r.req_cycles++;
            if (r.req_cycles == 1) begin
                r.sel = sel; r.we = we; r.maddr = maddr; r.wdata = wd;
            end else if (sel !== r.sel || we !== r.we || maddr !== r.maddr || wd !== r.wdata) begin
                r.stable = 1'b0;
            end
        end
        if (mwr) begin
            r.mapper_cycles++;
            if (r.mapper_cycles == 1) begin
                r.mapper_first = cyc; r.mdata = mdata;
            end
        end
        if (rdy) begin
            r.ready_cyc = cyc; r.rd_data = rdd; r.err = err;
        end
    endtask

    // Strobe in cycle 0, then observe both instances until each has completed.
    task automatic run(input logic [15:0] addr, input logic rd, input logic wr,
                       input logic [7:0] wdata, input int ack_cyc, input logic [7:0] ack_data,
                       input bit noise, output res_t ra, output res_t rb);
        ra = '{default: '0}; rb = '{default: '0};
        ra.stable = 1'b1; rb.stable = 1'b1;
        @(posedge clk_i); #1;
        cpu_addr_i = addr; cpu_rd_i = rd; cpu_wr_i = wr; cpu_wr_data_i = wdata;
        for (int cyc = 1; cyc <= 40 && (ra.ready_cyc == 0 || rb.ready_cyc == 0); cyc++) begin
            @(posedge clk_i); #1;
            cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; mem_ack_i = 1'b0;
            sample(cyc, req_a, sel_a, we_a, maddr_a, wd_a, mwr_a, mwd_a, ready_a, rd_data_a, err_a, ra);
            sample(cyc, req_b, sel_b, we_b, maddr_b, wd_b, mwr_b, mwd_b, ready_b, rd_data_b, err_b, rb);
            if (noise) begin
                cpu_wr_i = 1'b1; cpu_addr_i = 16'h8000; cpu_wr_data_i = 8'hEE;
            end
            if (cyc == ack_cyc) begin
                mem_ack_i = 1'b1; mem_rd_data_i = ack_data;
            end
        end
        mem_ack_i = 1'b0;
    endtask

    vec_t vecs[11];
    res_t ra, rb;
    int   pulses;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'hC123, 1'b1, 1'b0, 8'h00, 1, 8'hA5, 2, 1, 1'b0, 1'b0, 19'h1C123, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[1]  = '{16'h8000, 1'b0, 1'b1, 8'h03, 0, 8'h00, 2, 0, 1'b0, 1'b0, 19'h00000, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{16'h6010, 1'b0, 1'b1, 8'h5A, 4, 8'h00, 5, 4, 1'b1, 1'b1, 19'h00010, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{16'h8004, 1'b1, 1'b0, 8'h00, 2, 8'h77, 3, 2, 1'b0, 1'b0, 19'h18004, 1'b0, 1'b1, 8'h77, 1'b0};
        vecs[4]  = '{16'h5000, 1'b1, 1'b0, 8'h00, 0, 8'h00, 2, 0, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b1, 8'h77, 1'b0};
        vecs[5]  = '{16'h6001, 1'b1, 1'b1, 8'h3C, 1, 8'hFF, 2, 1, 1'b1, 1'b1, 19'h00001, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{16'h7FFF, 1'b1, 1'b0, 8'h00, 3, 8'h42, 4, 3, 1'b1, 1'b0, 19'h01FFF, 1'b0, 1'b1, 8'h42, 1'b0};
        vecs[7]  = '{16'hFFFF, 1'b1, 1'b0, 8'h00, 8, 8'h99, 9, 8, 1'b0, 1'b0, 19'h1FFFF, 1'b0, 1'b1, 8'h99, 1'b0};
        vecs[8]  = '{16'h4020, 1'b0, 1'b1, 8'h11, 0, 8'h00, 2, 0, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{16'h9000, 1'b1, 1'b0, 8'h00, 0, 8'h00, 9, 8, 1'b0, 1'b0, 19'h19000, 1'b0, 1'b1, 8'h11, 1'b1};
        vecs[10] = '{16'h8000, 1'b1, 1'b0, 8'h00, 1, 8'h55, 2, 1, 1'b0, 1'b0, 19'h18000, 1'b0, 1'b1, 8'h55, 1'b1};

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("reset mem_req", 32'(req_a), 32'd0);
        check("reset cpu_ready", 32'(ready_a), 32'd0);
        check("reset mapper_wr", 32'(mwr_a), 32'd0);
        check("reset err_timeout", 32'(err_a), 32'd0);
        check("reset rd_data", 32'(rd_data_a), 32'd0);
        check("reset prg_rom_addr", 32'(rom_a), 32'd0);
        check("reset mem_addr", 32'(maddr_a), 32'd0);
        check("reset mem_we/sel", 32'({we_a, sel_a}), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].ack_cyc,
                vecs[i].ack_data, 1'b0, ra, rb);
            check($sformatf("v%0d ready_cycle", i), 32'(ra.ready_cyc), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d req_cycles", i), 32'(ra.req_cycles), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req > 0) begin
                check($sformatf("v%0d mem_sel", i), 32'(ra.sel), 32'(vecs[i].exp_sel));
                check($sformatf("v%0d mem_we", i), 32'(ra.we), 32'(vecs[i].exp_we));
                check($sformatf("v%0d mem_addr", i), 32'(ra.maddr), 32'(vecs[i].exp_maddr));
                check($sformatf("v%0d req_stable", i), 32'(ra.stable), 32'd1);
                if (vecs[i].exp_we)
                    check($sformatf("v%0d mem_wr_data", i), 32'(ra.wdata), 32'(vecs[i].wdata));
            end
            check($sformatf("v%0d mapper_wr_cycles", i), 32'(ra.mapper_cycles), 32'(vecs[i].exp_map));
            if (vecs[i].exp_map) begin
                check($sformatf("v%0d mapper_wr_cycle", i), 32'(ra.mapper_first), 32'd1);
                check($sformatf("v%0d mapper_wr_data", i), 32'(ra.mdata), 32'(vecs[i].wdata));
            end
            if (vecs[i].chk_rd)
                check($sformatf("v%0d rd_data", i), 32'(ra.rd_data), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d err_timeout", i), 32'(ra.err), 32'(vecs[i].exp_err));
        end

        // PRG RAM disabled: $6000 reads behave as open-bus, no request.
        run(16'h8004, 1'b1, 1'b0, 8'h00, 1, 8'h77, 1'b0, ra, rb);
        check("b prep rd_data", 32'(rb.rd_data), 32'h77);
        run(16'h6000, 1'b1, 1'b0, 8'h00, 1, 8'h11, 1'b0, ra, rb);
        check("b ram-off ready_cycle", 32'(rb.ready_cyc), 32'd2);
        check("b ram-off req_cycles", 32'(rb.req_cycles), 32'd0);
        check("b ram-off rd_data", 32'(rb.rd_data), 32'h77);
        check("a ram-on req_cycles", 32'(ra.req_cycles), 32'd1);
        check("a ram-on rd_data", 32'(ra.rd_data), 32'h11);

        // Strobes during MEM and DONE must be ignored.
        run(16'h8010, 1'b1, 1'b0, 8'h00, 3, 8'h66, 1'b1, ra, rb);
        check("busy strobe ready_cycle", 32'(ra.ready_cyc), 32'd4);
        check("busy strobe mapper_wr", 32'(ra.mapper_cycles), 32'd0);
        check("busy strobe addr_stable", 32'(ra.stable), 32'd1);
        check("busy strobe mem_addr", 32'(ra.maddr), 32'h18010);
        check("busy strobe rd_data", 32'(ra.rd_data), 32'h66);
        @(posedge clk_i); #1;
        cpu_wr_i = 1'b0;
        check("done strobe ignored mapper_wr", 32'(mwr_a), 32'd0);
        check("done strobe ignored activity", 32'({req_a, ready_a}), 32'd0);

        // Reset in cycle 3 of a pending read.
        @(posedge clk_i); #1;
        cpu_addr_i = 16'h9000; cpu_rd_i = 1'b1;
        @(posedge clk_i); #1;
        cpu_rd_i = 1'b0;
        check("rst-mid req cycle1", 32'(req_a), 32'd1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rst-mid req cycle4", 32'(req_a), 32'd0);
        check("rst-mid err cleared", 32'(err_a), 32'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (ready_a) pulses++;
            @(posedge clk_i); #1;
        end
        check("rst-mid no ready pulse", 32'(pulses), 32'd0);
        run(16'hC123, 1'b1, 1'b0, 8'h00, 1, 8'hA5, 1'b0, ra, rb);
        check("post-rst ready_cycle", 32'(ra.ready_cyc), 32'd2);
        check("post-rst mem_addr", 32'(ra.maddr), 32'h1C123);
        check("post-rst rd_data", 32'(ra.rd_data), 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
